// File: rtl/my_74ls161_if.sv
// Data/control bundle for the my_74ls161 4-bit counter.
//   LD   : parallel load, active-low, synchronous
//   CTP  : count enable P, active-high
//   CTT  : count enable T, active-high; also gates Co
//   D    : parallel load data, D[0] is the LSB
//   Co   : ripple carry out, combinational
//   Q    : counter state, Q[0] is the LSB
// master drives the controls and data; slave is the counter.
interface my_74ls161_if;
  logic       LD;
  logic       CTP;
  logic       CTT;
  logic [3:0] D;
  logic       Co;
  logic [3:0] Q;

  modport master (
    output LD, CTP, CTT, D,
    input  Co, Q
  );

  modport slave (
    input  LD, CTP, CTT, D,
    output Co, Q
  );
endinterface

// File: rtl/my_74ls161.sv
// 4-bit synchronous binary counter modelled on the 74LS161, with an
// active-high asynchronous clear.
//   CP  : clock, all synchronous actions on the rising edge
//   CR  : asynchronous clear, active-high, forces Q to 0
//   bus : my_74ls161_if slave (LD, CTP, CTT, D in; Co, Q out)
// Priority: CR > load > count > hold. Co = CTT & (Q == 15) and is
// independent of CTP and LD, so it can feed the next stage's CTT.
module my_74ls161 (
  input logic         CP,
  input logic         CR,
  my_74ls161_if.slave bus
);

  logic [3:0] count;

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      count <= '0;
    end else if (!bus.LD) begin
      count <= bus.D;
    end else if (bus.CTP && bus.CTT) begin
      count <= count + 4'd1;
    end
  end

  assign bus.Q  = count;
  // Q is held at 0 during clear, so Co is low then without extra gating.
  assign bus.Co = bus.CTT & (count == 4'hF);

endmodule

// File: tb/tb_my_74ls161.sv
module tb_my_74ls161;

  logic CP;
  logic CR;
  int unsigned checks;
  int unsigned errors;

  my_74ls161_if bus ();

  my_74ls161 dut (
    .CP  (CP),
    .CR  (CR),
    .bus (bus.slave)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Rising edge, then settle before sampling.
  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic drive(input logic ld, input logic ctp, input logic ctt, input logic [3:0] d);
    @(negedge CP);
    bus.LD  = ld;
    bus.CTP = ctp;
    bus.CTT = ctt;
    bus.D   = d;
  endtask

  logic [3:0] exp_q [6];

  initial begin
    #100000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    exp_q  = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
    CR      = 1'b1;
    bus.LD  = 1'b1;
    bus.CTP = 1'b0;
    bus.CTT = 1'b1;
    bus.D   = 4'd0;
    #2;
    check("reset_q", bus.Q, 4'd0);
    check("reset_co", {3'b0, bus.Co}, 4'd0);
    @(negedge CP);
    CR = 1'b0;

    // 1. Clear: reach Q=9, then clear mid-cycle without an edge.
    drive(1'b0, 1'b0, 1'b0, 4'd9);
    tick();
    check("pre_clear_q", bus.Q, 4'd9);
    #2;
    CR = 1'b1;
    #1;
    check("async_clear_q", bus.Q, 4'd0);
    check("async_clear_co", {3'b0, bus.Co}, 4'd0);
    drive(1'b0, 1'b1, 1'b1, 4'd12);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("clear_hold_q", bus.Q, 4'd0);
    end
    @(negedge CP);
    CR = 1'b0;

    // 2. Load, with and without count enables.
    drive(1'b0, 1'b0, 1'b0, 4'd12);
    tick();
    check("load_q", bus.Q, 4'd12);
    check("load_co", {3'b0, bus.Co}, 4'd0);
    drive(1'b0, 1'b1, 1'b1, 4'd12);
    tick();
    check("load_beats_count", bus.Q, 4'd12);

    // 3. Count through the wrap.
    drive(1'b1, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("count_q", bus.Q, exp_q[i]);
      check("count_co", {3'b0, bus.Co}, (exp_q[i] == 4'd15) ? 4'd1 : 4'd0);
    end

    // 4. Hold with either enable low.
    drive(1'b0, 1'b0, 1'b0, 4'd5);
    tick();
    drive(1'b1, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold_ctp0_q", bus.Q, 4'd5);
      check("hold_ctp0_co", {3'b0, bus.Co}, 4'd0);
    end
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold_ctt0_q", bus.Q, 4'd5);
    end

    // 5. Carry gating: load 15 with CTT=1, CTP=0.
    drive(1'b0, 1'b0, 1'b1, 4'd15);
    tick();
    check("load15_q", bus.Q, 4'd15);
    check("load15_co", {3'b0, bus.Co}, 4'd1);
    drive(1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    check("hold15_q", bus.Q, 4'd15);
    check("hold15_co", {3'b0, bus.Co}, 4'd1);
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    #1;
    check("ctt0_co", {3'b0, bus.Co}, 4'd0);
    drive(1'b1, 1'b1, 1'b1, 4'd0);
    #1;
    check("co_before_wrap", {3'b0, bus.Co}, 4'd1);
    tick();
    check("wrap_q", bus.Q, 4'd0);
    check("wrap_co", {3'b0, bus.Co}, 4'd0);

    // 6. Mid-count clear at Q=7, then resume from 0.
    for (int i = 0; i < 7; i++) tick();
    check("mid_count_q", bus.Q, 4'd7);
    #2;
    CR = 1'b1;
    #1;
    check("mid_count_clear_q", bus.Q, 4'd0);
    tick();
    check("clear_blocks_count", bus.Q, 4'd0);
    @(negedge CP);
    CR = 1'b0;
    tick();
    check("resume_q", bus.Q, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_74ls161.md
Name: my_74ls161

Overview:
- 4-bit synchronous binary counter, functionally equivalent to the 74LS161 except for clear polarity.
- Supports asynchronous clear, synchronous parallel load, dual count enables and a ripple-carry output.
- Used as a counter/divider building block; Co chains into the next stage's CTT to cascade wider counters.

Parameters:
- None. Width is fixed at 4 bits.

Ports:
- CP  input  1  clock; all synchronous actions occur on the rising edge.
- CR  input  1  clear; asynchronous, active-high; forces Q=0.
- LD  input  1  parallel load; synchronous, active-low.
- CTP  input  1  count enable P; active-high.
- CTT  input  1  count enable T; active-high; also gates Co.
- D  input  4  parallel load data; D[0] is the LSB.
- Co  output  1  ripple carry out; combinational.
- Q  output  4  counter state; Q[0] is the LSB.

Behaviour:
- Interface: one clock (CP); reset (CR) is asynchronous and active-high.
- Priority, highest first: CR > LD > count > hold.
- CR=1:
  - Q goes to 4'b0000 immediately, without waiting for a CP edge.
  - Q stays at 0 for as long as CR=1; CP edges and all other inputs are ignored.
  - Co is 0 while CR=1.
- CR=0, rising edge of CP, LD=0:
  - Q <= D.
  - Load happens regardless of CTP and CTT.
- CR=0, rising edge of CP, LD=1, CTP=1 and CTT=1:
  - Q <= Q+1, modulo 16.
  - 4'b1111 wraps to 4'b0000; no sticky overflow flag.
- CR=0, rising edge of CP, LD=1, CTP=0 or CTT=0:
  - Q holds its value.
- Co:
  - Co = CTT AND (Q == 4'b1111), purely combinational.
  - Co does NOT depend on CTP or LD.
  - With CTT=1 and Q=15, Co is high for the whole cycle and drops when Q wraps to 0.
- Latency:
  - Load and count take effect exactly one rising edge after the inputs are sampled.
  - Clear is zero-latency (asynchronous).
- CR deasserted (1->0) between clock edges: the next rising edge performs a normal load, count or hold from Q=0.
- CR asserted mid-cycle: clears at once; any pending load or count is discarded.
- Load of D=4'b1111 with CTT=1: Co asserts right after that load edge.
- Power-up: Q is undefined until the first CR assertion. Every bench must assert CR first.
- Inputs change only away from the CP rising edge; no setup/hold checking is required in RTL.

Test Plan:
1. Clear: Q=9, CR=1 mid-cycle with no CP edge -> Q=0 immediately, Co=0. Keep CR=1 for 3 edges with LD=0 and D=12 -> Q stays 0.
2. Load: CR=0, LD=0, D=4'b1100, CTP=CTT=0, one rising edge -> Q=12, Co=0. Repeat with CTP=CTT=1 -> still Q=12, because load beats count.
3. Count and wrap: from Q=12 with LD=1, CTP=CTT=1, six edges -> Q=13,14,15,0,1,2. Co=1 only while Q=15.
4. Hold: at Q=5, CTP=0/CTT=1 for 2 edges -> Q=5, Co=0. Then CTP=1/CTT=0 for 2 edges -> Q=5.
5. Carry gating: load 4'b1111, then CTT=1/CTP=0 -> Co=1 and Q holds 15. CTT=0 -> Co=0. CTT=1/CTP=1 plus one edge -> Q=0, Co=0.
6. Mid-count reset: counting from 0, assert CR=1 at Q=7 between edges -> Q=0 at once. Deassert CR; next edge -> Q=1.
